// File: rtl/fifo_regfile.sv
`default_nettype none
// ============================================================================
// Module   : fifo_regfile
// Brief    : Synchronous FIFO over a DEPTH x DATA_W register file with
//            one-hot per-entry write enables, occupancy count, registered
//            status flags and per-direction ack/err handshake outputs.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_regfile #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] d_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] d_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [AW:0]       data_count,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  localparam logic [AW:0] C_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AFULL_TH = (AW+1)'(AFULL_TH);

  // Handshake status of the most recent edge.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_READ   = 3'd2,
    S_WR_RD  = 3'd3,
    S_WR_ERR = 3'd4,
    S_RD_ERR = 3'd5
  } state_t;

  // Storage and bookkeeping
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  wr_sel;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  state_t            state_q, state_d;
  // Set when the direction opposite to the error was accepted in that cycle.
  logic              other_ok_q, other_ok_d;

  logic              wr_ok;
  logic              rd_ok;

  // Acceptance is judged against the pre-edge flags only.
  assign wr_ok = wr_en & ~full_q;
  assign rd_ok = rd_en & ~empty_q;

  // One-hot write decode: only the entry at wr_ptr loads.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign wr_sel[gi] = wr_ok && (wr_ptr_q == AW'(gi));
      assign mem_d[gi]  = wr_sel[gi] ? d_in : mem_q[gi];
    end
  endgenerate

  // Register file entries; cleared on reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Next pointers, count, read data and status flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    d_out_d  = d_out_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      d_out_d  = mem_q[rd_ptr_q];
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == C_DEPTH);
    empty_d = (count_d == '0);
    afull_d = (count_d >= C_AFULL_TH);
  end

  // Handshake state from request and outcome; an error takes the state and
  // the accepted opposite direction is remembered in other_ok.
  always_comb begin
    state_d    = S_IDLE;
    other_ok_d = 1'b0;
    if (wr_en && full_q) begin
      state_d    = S_WR_ERR;
      other_ok_d = rd_ok;
    end else if (rd_en && empty_q) begin
      state_d    = S_RD_ERR;
      other_ok_d = wr_ok;
    end else if (wr_ok && rd_ok) begin
      state_d = S_WR_RD;
    end else if (wr_ok) begin
      state_d = S_WRITE;
    end else if (rd_ok) begin
      state_d = S_READ;
    end
  end

  // Datapath and status registers; reset overrides any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      d_out_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= (C_AFULL_TH == '0);
      state_q    <= S_IDLE;
      other_ok_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      d_out_q    <= d_out_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      state_q    <= state_d;
      other_ok_q <= other_ok_d;
    end
  end

  // Outputs are decoded purely from registers.
  assign d_out       = d_out_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = afull_q;
  assign data_count  = count_q;

  assign wr_err = (state_q == S_WR_ERR);
  assign rd_err = (state_q == S_RD_ERR);
  assign wr_ack = (state_q == S_WRITE) || (state_q == S_WR_RD) ||
                  ((state_q == S_RD_ERR) && other_ok_q);
  assign rd_ack = (state_q == S_READ) || (state_q == S_WR_RD) ||
                  ((state_q == S_WR_ERR) && other_ok_q);

endmodule
`default_nettype wire

// File: tb/tb_fifo_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_regfile
// Brief    : Directed bench for fifo_regfile (32x32 and 4x8 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32 x 32 instance
  logic        reset, wr_en, rd_en;
  logic [31:0] d_in, d_out;
  logic        full, empty, almost_full, wr_ack, wr_err, rd_ack, rd_err;
  logic [5:0]  data_count;

  // 4 x 8 instance
  logic        reset2, wr_en2, rd_en2;
  logic [7:0]  d_in2, d_out2;
  logic        full2, empty2, almost_full2, wr_ack2, wr_err2, rd_ack2, rd_err2;
  logic [2:0]  data_count2;

  int checks = 0;
  int errors = 0;

  fifo_regfile #(.DATA_W(32), .DEPTH(32)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
    .d_out(d_out), .full(full), .empty(empty), .almost_full(almost_full),
    .data_count(data_count), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err)
  );

  fifo_regfile #(.DATA_W(8), .DEPTH(4)) u_dut2 (
    .clk(clk), .reset(reset2), .wr_en(wr_en2), .d_in(d_in2), .rd_en(rd_en2),
    .d_out(d_out2), .full(full2), .empty(empty2), .almost_full(almost_full2),
    .data_count(data_count2), .wr_ack(wr_ack2), .wr_err(wr_err2),
    .rd_ack(rd_ack2), .rd_err(rd_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input int cnt, input logic f, input logic e, input logic af);
    check({tag, ".count"}, 32'(data_count), 32'(cnt));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".empty"}, 32'(empty), 32'(e));
    check({tag, ".afull"}, 32'(almost_full), 32'(af));
  endtask

  task automatic check_hs(input string tag, input logic wa, input logic we, input logic ra, input logic re);
    check({tag, ".wr_ack"}, 32'(wr_ack), 32'(wa));
    check({tag, ".wr_err"}, 32'(wr_err), 32'(we));
    check({tag, ".rd_ack"}, 32'(rd_ack), 32'(ra));
    check({tag, ".rd_err"}, 32'(rd_err), 32'(re));
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; d_in = '0;
    reset2 = 1'b1; wr_en2 = 1'b0; rd_en2 = 1'b0; d_in2 = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state after three idle cycles
    tick(); tick(); tick();
    check_flags("reset", 0, 1'b0, 1'b1, 1'b0);
    check("reset.d_out", d_out, 32'h0);
    check_hs("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill with 0x1..0x20
    for (int i = 1; i <= 32; i++) begin
      wr_en = 1'b1; d_in = 32'(i);
      tick();
      check_hs("fill", 1'b1, 1'b0, 1'b0, 1'b0);
      check_flags("fill", i, (i == 32), 1'b0, (i >= 30));
    end
    // Write while full is rejected
    d_in = 32'hDEAD;
    tick();
    check_hs("ovf", 1'b0, 1'b1, 1'b0, 1'b0);
    check_flags("ovf", 32, 1'b1, 1'b0, 1'b1);
    wr_en = 1'b0;

    // Drain in order
    for (int i = 1; i <= 32; i++) begin
      rd_en = 1'b1;
      tick();
      check_hs("drain", 1'b0, 1'b0, 1'b1, 1'b0);
      check("drain.d_out", d_out, 32'(i));
      check_flags("drain", 32 - i, 1'b0, (i == 32), ((32 - i) >= 30));
    end
    // Read while empty is rejected, d_out holds
    tick();
    check_hs("udf", 1'b0, 1'b0, 1'b0, 1'b1);
    check("udf.d_out", d_out, 32'h20);
    check_flags("udf", 0, 1'b0, 1'b1, 1'b0);
    rd_en = 1'b0;

    // Pointer wrap: two rounds of 20 words
    for (int r = 1; r <= 2; r++) begin
      for (int k = 0; k < 20; k++) begin
        wr_en = 1'b1; d_in = 32'(r * 256 + k);
        tick();
      end
      wr_en = 1'b0;
      check("wrap.count_full", 32'(data_count), 32'd20);
      for (int k = 0; k < 20; k++) begin
        rd_en = 1'b1;
        tick();
        check("wrap.d_out", d_out, 32'(r * 256 + k));
      end
      rd_en = 1'b0;
      check_flags("wrap.end", 0, 1'b0, 1'b1, 1'b0);
    end

    // Both requests at empty: write wins, no bypass
    wr_en = 1'b1; rd_en = 1'b1; d_in = 32'hA5;
    tick();
    check_hs("both_empty", 1'b1, 1'b0, 1'b0, 1'b1);
    check_flags("both_empty", 1, 1'b0, 1'b0, 1'b0);
    check("both_empty.d_out", d_out, 32'h213);
    rd_en = 1'b0;

    // Fill to full behind 0xA5
    for (int k = 0; k < 31; k++) begin
      d_in = 32'h300 + 32'(k);
      tick();
    end
    check_flags("refill", 32, 1'b1, 1'b0, 1'b1);

    // Both requests at full: read wins
    rd_en = 1'b1; d_in = 32'hEE;
    tick();
    check_hs("both_full", 1'b0, 1'b1, 1'b1, 1'b0);
    check_flags("both_full", 31, 1'b0, 1'b0, 1'b1);
    check("both_full.d_out", d_out, 32'hA5);
    wr_en = 1'b0;

    // Drain down to 5 entries
    for (int k = 0; k < 26; k++) begin
      tick();
      check("down.d_out", d_out, 32'h300 + 32'(k));
    end
    check_flags("down", 5, 1'b0, 1'b0, 1'b0);

    // Both requests at mid occupancy: both accepted
    wr_en = 1'b1; d_in = 32'h77;
    tick();
    check_hs("both_mid", 1'b1, 1'b0, 1'b1, 1'b0);
    check_flags("both_mid", 5, 1'b0, 1'b0, 1'b0);
    check("both_mid.d_out", d_out, 32'h31A);
    rd_en = 1'b0;

    // Grow to 10 then reset with a write pending
    for (int k = 0; k < 5; k++) begin
      d_in = 32'h400 + 32'(k);
      tick();
    end
    check("pre_rst.count", 32'(data_count), 32'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0;
    check_flags("mid_rst", 0, 1'b0, 1'b1, 1'b0);
    check_hs("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_rst.d_out", d_out, 32'h0);
    // Contents discarded: a read is rejected
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_hs("post_rst_rd", 1'b0, 1'b0, 1'b0, 1'b1);

    // Small instance: DATA_W=8, DEPTH=4, AFULL_TH=2
    reset2 = 1'b0;
    tick();
    check("s.empty", 32'(empty2), 32'd1);
    wr_en2 = 1'b1;
    d_in2 = 8'h11; tick();
    check("s.afull1", 32'(almost_full2), 32'd0);
    d_in2 = 8'h22; tick();
    check("s.afull2", 32'(almost_full2), 32'd1);
    d_in2 = 8'h33; tick();
    d_in2 = 8'h44; tick();
    check("s.full", 32'(full2), 32'd1);
    check("s.count4", 32'(data_count2), 32'd4);
    d_in2 = 8'h55; tick();
    check("s.wr_err", 32'(wr_err2), 32'd1);
    check("s.wr_ack_ovf", 32'(wr_ack2), 32'd0);
    rd_en2 = 1'b1; wr_en2 = 1'b0;
    tick();
    rd_en2 = 1'b0;
    check("s.d_out", 32'(d_out2), 32'h11);
    check("s.count3", 32'(data_count2), 32'd3);
    wr_en2 = 1'b1; d_in2 = 8'h66;
    tick();
    check("s.count_back4", 32'(data_count2), 32'd4);
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0; wr_en2 = 1'b0;
    check("s.rst_count", 32'(data_count2), 32'd0);
    check("s.rst_empty", 32'(empty2), 32'd1);
    check("s.rst_full", 32'(full2), 32'd0);
    check("s.rst_afull", 32'(almost_full2), 32'd0);
    check("s.rst_wr_ack", 32'(wr_ack2), 32'd0);
    check("s.rst_d_out", 32'(d_out2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_regfile.md
# fifo_regfile

Parametrised synchronous FIFO built on a DEPTH × DATA_W register file with enable-per-entry writes. It generalises the fixed 32-entry × 32-bit output register bank into a self-managing queue with pointers, occupancy count, status flags and per-request ack/error handshakes. It sits between the factorial datapath and the output bus, buffering result words until the bus master drains them.

## Interface
- DATA_W, 32, data word width (≥1)
- DEPTH, 32, number of entries; power of two, 2..1024
- AW, $clog2(DEPTH), pointer width (derived, not overridden)
- AFULL_TH, DEPTH-2, almost_full asserted when count ≥ AFULL_TH (1..DEPTH)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request, sampled each rising edge
- d_in  in  DATA_W  write data
- rd_en  in  1  read request, sampled each rising edge
- d_out  out  DATA_W  registered read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- data_count  out  AW+1  current occupancy, 0..DEPTH
- wr_ack  out  1  previous-cycle write accepted
- wr_err  out  1  previous-cycle write rejected (full)
- rd_ack  out  1  previous-cycle read accepted; d_out valid
- rd_err  out  1  previous-cycle read rejected (empty)

## Operation
- Storage: DEPTH registers, one-hot write enable decoded from wr_ptr; only the addressed entry loads.
- Pointers wr_ptr, rd_ptr (AW bits) wrap DEPTH-1 → 0 by natural overflow; count kept separately (AW+1 bits).
- Per edge, with wr_ok = wr_en & ~full, rd_ok = rd_en & ~empty (flags = pre-edge values):
  - wr_ok: mem[wr_ptr] ← d_in, wr_ptr+1.
  - rd_ok: d_out ← mem[rd_ptr], rd_ptr+1.
  - count: +1 if wr_ok only, −1 if rd_ok only, unchanged if both or neither.
- Full with wr_en & rd_en: read accepted, write rejected (wr_err=1); count → DEPTH−1.
- Empty with wr_en & rd_en: write accepted, read rejected (rd_err=1), no bypass; count → 1.
- Neither-full-nor-empty with both: both accepted, count unchanged.
- d_out holds its value when no read is accepted (including rd_err cycles).
- Status FSM (registered, drives ack/err): IDLE, WRITE, READ, WR_RD, WR_ERR, RD_ERR. State chosen each edge from request and outcome; both requests with one rejected encode the accepted op in ack and the rejected in err. ack/err are one-hot-per-direction, never wr_ack & wr_err together.
- Reset: all entries, d_out, pointers, count → 0; empty=1, full=0, almost_full=(AFULL_TH==0 ? 1:0, i.e. 0 for legal params); all ack/err=0; FSM → IDLE. Reset overrides any simultaneous request; reset mid-stream discards contents.

## Timing
- Write latency: data written on edge N readable by rd_en sampled at edge N+1; d_out valid after edge N+1.
- Read latency: 1 cycle; rd_ack and d_out update on the same edge.
- full/empty/almost_full/data_count are registered, consistent with count after each edge; no combinational path from wr_en/rd_en to any output.
- Sustained wr_en & rd_en at mid occupancy: one word in and out per cycle, indefinitely.

## Test plan
- Reset, then idle 3 cycles -> empty=1, full=0, data_count=0, d_out=0, all ack/err=0.
- Write 0x1..0x20 in 32 consecutive cycles (DEPTH=32) -> wr_ack each cycle, almost_full rises when count=30, full=1 after 32nd; 33rd write -> wr_err=1, count stays 32.
- From full, read 32 cycles -> d_out 0x1..0x20 in order with rd_ack; empty=1 after last; extra read -> rd_err=1, d_out holds 0x20.
- Pointer wrap: write 20, read 20, write 20, read 20 -> read order matches write order across wrap, count returns 0.
- Simultaneous wr/rd at empty (d_in=0xA5) -> wr_ack=1, rd_err=1, count=1; at full -> rd_ack=1, wr_err=1, count=31; at count=5 -> both ack, count 5.
- reset asserted with wr_en=1 at count=10 -> next cycle count=0, empty=1, wr_ack=0; repeat with DATA_W=8, DEPTH=4.
